data_mem_ls: RTL and testbench

DATA_MEM_LS -- requirements
Module: data_mem_ls

---
 rtl/data_mem_ls.sv | 231 +++++++++++++++++++++++
 tb/tb_data_mem_ls.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ls.sv
// data_mem_ls: single-port word memory with RISC-V style byte/half/word
// load-store access, a fixed programmable access latency and a one-cycle
// response strobe.
//
// Parameters:
//   DEPTH   - number of 32-bit words (power of two, 4..4096)
//   LATENCY - wait cycles between acceptance and array access (0..15)
//
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   req_valid   - request present
//   req_ready   - high only while idle; a request is taken when both are high
//   req_we      - 1 = store, 0 = load
//   req_addr    - byte address (bits above the array size are ignored)
//   req_wdata   - right-aligned store data
//   req_funct3  - size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   rsp_valid   - one-cycle response strobe
//   rsp_rdata   - extended load data, zero for stores and errors
//   rsp_err     - request rejected (illegal size code or misaligned access)
//
// Build option:
//   DATA_MEM_LS_MISALIGN_TRAP_EN - when defined, misaligned half/word
//   accesses are rejected; otherwise the offending low address bits are
//   ignored.

module data_mem_ls #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic            do_access;

  // Request fields captured at acceptance
  logic            lat_we;
  logic [AW+1:0]   lat_addr;
  logic [31:0]     lat_wdata;
  logic [2:0]      lat_f3;

  // Access-side view of the request and derived datapath signals
  logic            acc_we;
  logic [AW+1:0]   acc_addr;
  logic [31:0]     acc_wdata;
  logic [2:0]      acc_f3;
  logic [AW-1:0]   acc_idx;
  logic [1:0]      acc_lane;
  logic            f3_bad;
  logic            misalign;
  logic            acc_err;
  logic [31:0]     rd_word;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [31:0]     load_data;
  logic [3:0]      wr_be;
  logic [31:0]     wr_data;
  logic            mem_we;

  logic            rsp_valid_d;
  logic [31:0]     rsp_rdata_d;
  logic            rsp_err_d;

  logic [31:0]     mem [DEPTH];

  // Address bits above the array are intentionally ignored (wrap)
  logic            unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW+2];

  // State register, capture registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_f3    <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      req_ready <= (state_next == ST_IDLE);
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      if (state == ST_IDLE && req_valid) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr[AW+1:0];
        lat_wdata <= req_wdata;
        lat_f3    <= req_funct3;
      end
    end
  end

  // Next-state logic; do_access marks the edge on which the array is touched
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    do_access  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_next = ST_RESP;
            do_access  = 1'b1;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = CW'(LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_next = ST_RESP;
          do_access  = 1'b1;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath and next values of the registered outputs
  always_comb begin
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    mem_we      = 1'b0;

    // With zero latency the access happens on the acceptance edge itself
    if (state == ST_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr[AW+1:0];
      acc_wdata = req_wdata;
      acc_f3    = req_funct3;
    end else begin
      acc_we    = lat_we;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_f3    = lat_f3;
    end
    acc_idx  = acc_addr[AW+1:2];
    acc_lane = acc_addr[1:0];

    case (acc_f3)
      3'b000, 3'b001, 3'b010: f3_bad = 1'b0;
      3'b100, 3'b101:         f3_bad = acc_we;
      default:                f3_bad = 1'b1;
    endcase

`ifdef DATA_MEM_LS_MISALIGN_TRAP_EN
    misalign = ((acc_f3[1:0] == 2'b01) && acc_lane[0]) ||
               ((acc_f3[1:0] == 2'b10) && (acc_lane != 2'b00));
`else
    misalign = 1'b0;
`endif
    acc_err = f3_bad || misalign;

    rd_word = mem[acc_idx];
    rd_byte = rd_word[{acc_lane, 3'b000} +: 8];
    rd_half = acc_lane[1] ? rd_word[31:16] : rd_word[15:0];

    case (acc_f3)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'd0, rd_byte};
      3'b101:  load_data = {16'd0, rd_half};
      default: load_data = '0;
    endcase

    // Store data is replicated across lanes; the byte enables pick the target
    case (acc_f3[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << acc_lane;
        wr_data = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = acc_lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{acc_wdata[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = acc_wdata;
      end
    endcase

    if (do_access) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = acc_err;
      if (!acc_err && !acc_we) rsp_rdata_d = load_data;
      mem_we = acc_we && !acc_err;
    end
  end

  // Array write port; contents survive reset, but reset blocks a pending store
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[acc_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ls.sv
module tb_data_mem_ls;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned LAT   = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  data_mem_ls #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          ncyc   = 0;
  logic [7:0]  mb [DEPTH*4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // Byte-addressed little-endian reference memory
  task automatic model_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input bit commit,
                          output logic [31:0] rd, output logic err);
    int unsigned ba, base, n;
    logic [31:0] v;
    bit          sgn;
    ba  = addr % (DEPTH*4);
    n   = 1;
    sgn = 1'b0;
    err = 1'b0;
    rd  = '0;
    case (f3)
      3'd0: begin n = 1; sgn = 1'b1; end
      3'd1: begin n = 2; sgn = 1'b1; end
      3'd2: n = 4;
      3'd4: n = 1;
      3'd5: n = 2;
      default: err = 1'b1;
    endcase
    if (we && f3[2]) err = 1'b1;
`ifdef DATA_MEM_LS_MISALIGN_TRAP_EN
    if (!err && (ba % n) != 0) err = 1'b1;
`endif
    base = ba - (ba % n);
    if (!err) begin
      if (we) begin
        if (commit) for (int i = 0; i < int'(n); i++) mb[base+i] = wdata[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < int'(n); i++) v = v | (32'(mb[base+i]) << (8*i));
        if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        rd = v;
      end
    end
  endtask

  // Scoreboard monitor: every response must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: rsp_valid=1 with no request outstanding (cycle %0d)", ncyc);
      end else begin
        e = q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rd);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_timing", 32'(ncyc), 32'(e.due));
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, input bit use_exp, input logic [31:0] exp_rd,
                       input logic exp_err, input bit push, input bit hold);
    int   n;
    exp_t e;
    logic [31:0] mrd;
    logic merr;
    n = 0;
    @(negedge clk); #1;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (req_ready !== 1'b1) begin
      check("ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    model_op(we, addr, wdata, f3, push, mrd, merr);
    if (push) begin
      e.rd  = use_exp ? exp_rd : mrd;
      e.err = use_exp ? exp_err : merr;
      e.due = ncyc + int'(LAT) + 1;
      q.push_back(e);
    end
    @(negedge clk); #1;
    check("ready_after_accept", 32'(req_ready), 32'd0);
    if (hold) begin
      // Requests offered while busy must be dropped
      req_we     = 1'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      req_funct3 = 3'($urandom);
      for (int i = 0; i < int'(LAT); i++) begin
        @(negedge clk); #1;
      end
      @(negedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    logic [31:0] v;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_funct3 = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("ready_after_reset", 32'(req_ready), 32'd1);

    // Fill the whole array so every later load has defined data
    for (int w = 0; w < int'(DEPTH); w++)
      issue(1'b1, 32'(w*4), $urandom, 3'b010, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    drain();

    issue(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 3'b010, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
    issue(1'b1, 32'h13, 32'h7F, 3'b000, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 32'h13, 32'h0, 3'b000, 1'b1, 32'h0000007F, 1'b0, 1'b1, 1'b0);
    issue(1'b1, 32'h11, 32'h80, 3'b000, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 32'h11, 32'h0, 3'b000, 1'b1, 32'hFFFFFF80, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 32'h11, 32'h0, 3'b100, 1'b1, 32'h00000080, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 3'b010, 1'b1, 32'h7FAD80EF, 1'b0, 1'b1, 1'b1);
    issue(1'b1, 32'h100, 32'h12345678, 3'b010, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 32'h0, 32'h0, 3'b010, 1'b1, 32'h12345678, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 32'h2, 32'h0, 3'b101, 1'b1, 32'h00001234, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 32'h0, 32'h0, 3'b001, 1'b1, 32'h00005678, 1'b0, 1'b1, 1'b0);

`ifdef DATA_MEM_LS_MISALIGN_TRAP_EN
    issue(1'b0, 32'h11, 32'h0, 3'b010, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
    issue(1'b1, 32'h11, 32'h1111, 3'b001, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
    v = 32'h7FAD80EF;
`else
    issue(1'b0, 32'h11, 32'h0, 3'b010, 1'b1, 32'h7FAD80EF, 1'b0, 1'b1, 1'b0);
    issue(1'b1, 32'h11, 32'h1111, 3'b001, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    v = 32'h7FAD1111;
`endif
    issue(1'b0, 32'h10, 32'h0, 3'b010, 1'b1, v, 1'b0, 1'b1, 1'b0);
    issue(1'b1, 32'h10, 32'hFFFFFFFF, 3'b011, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 3'b110, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
    issue(1'b1, 32'h10, 32'hFFFFFFFF, 3'b100, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 3'b010, 1'b1, v, 1'b0, 1'b1, 1'b1);
    drain();

    // Reset lands on the access edge of a store: store and response vanish
    issue(1'b1, 32'h20, 32'hAAAA5555, 3'b010, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("rst_wait_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_wait_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_wait_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_wait_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    issue(1'b0, 32'h20, 32'h0, 3'b010, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    drain();

    for (int k = 0; k < 400; k++)
      issue(1'($urandom), $urandom, $urandom, 3'($urandom), 1'b0, '0, 1'b0, 1'b1, 1'($urandom));
    drain();
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
